usb_in_arbiter: RTL and testbench

Arbiter and commit sequencer for USB Endpoint 3 IN buffer, shared between two requesters (port 0: TS stream path, port 1: status/aux stream). Grants the endpoint buffer write port to one requester at a time, round-robin at commit granularity. Raises the endpoint commit with the granted requester's length and waits for the commit acknowledge (or a timeout). Sits between the TS processing blocks and the USB endpoint core.

---
 rtl/usb_arb_pkg.sv | 24 ++
 rtl/usb_in_arbiter_if.sv | 47 ++++
 rtl/ack_edge_sync.sv | 24 ++
 rtl/usb_in_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_usb_in_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_arb_pkg.sv
// Shared types and constants for the USB endpoint 3 IN arbiter.
package usb_arb_pkg;

  localparam int unsigned USB_LEN_W  = 11;
  localparam int unsigned USB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    COMMIT   = 2'd2,
    WAIT_ACK = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [USB_LEN_W-1:0]  addr;
    logic [USB_DATA_W-1:0] data;
    logic                  wren;
  } wr_port_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/usb_in_arbiter_if.sv
// Requester, endpoint-core and statistics signals of the EP3 IN arbiter.
interface usb_in_arbiter_if
  import usb_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic [1:0]            req;
  logic [1:0]            done;
  logic [USB_LEN_W-1:0]  len0;
  logic [USB_LEN_W-1:0]  len1;
  logic [USB_LEN_W-1:0]  addr0;
  logic [USB_LEN_W-1:0]  addr1;
  logic [USB_DATA_W-1:0] data0;
  logic [USB_DATA_W-1:0] data1;
  logic                  wren0;
  logic                  wren1;
  logic [1:0]            grant;
  logic [USB_LEN_W-1:0]  ep3_usb_in_addr;
  logic [USB_DATA_W-1:0] ep3_usb_in_data;
  logic                  ep3_usb_in_wren;
  logic                  ep3_usb_in_commit;
  logic [USB_LEN_W-1:0]  ep3_usb_in_commit_len;
  logic                  ep3_usb_in_ready;
  logic                  ep3_usb_in_commit_ack;
  logic [CNT_W-1:0]      commits0;
  logic [CNT_W-1:0]      commits1;
  logic [CNT_W-1:0]      timeouts;
  logic                  busy;

  modport master (
    output req, done, len0, len1, addr0, addr1, data0, data1, wren0, wren1,
    output ep3_usb_in_ready, ep3_usb_in_commit_ack,
    input  grant, ep3_usb_in_addr, ep3_usb_in_data, ep3_usb_in_wren,
    input  ep3_usb_in_commit, ep3_usb_in_commit_len,
    input  commits0, commits1, timeouts, busy
  );

  modport slave (
    input  req, done, len0, len1, addr0, addr1, data0, data1, wren0, wren1,
    input  ep3_usb_in_ready, ep3_usb_in_commit_ack,
    output grant, ep3_usb_in_addr, ep3_usb_in_data, ep3_usb_in_wren,
    output ep3_usb_in_commit, ep3_usb_in_commit_len,
    output commits0, commits1, timeouts, busy
  );

endinterface

// File: rtl/ack_edge_sync.sv
// Two-flop synchroniser for an asynchronous acknowledge, with a falling-edge pulse.
module ack_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_ack,
  output logic o_fall_c
);

  logic r_ack_1;
  logic r_ack_2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack_1 <= 1'b0;
      r_ack_2 <= 1'b0;
    end else begin
      r_ack_1 <= i_ack;
      r_ack_2 <= r_ack_1;
    end
  end

  assign o_fall_c = r_ack_2 & ~r_ack_1;

endmodule

// File: rtl/usb_in_arbiter.sv
// Round-robin arbiter and commit sequencer for the USB EP3 IN buffer (two requesters).
// Optional ACK timeout release enabled by defining USB_ARB_TIMEOUT_EN.
module usb_in_arbiter
  import usb_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 16
`ifdef USB_ARB_TIMEOUT_EN
  ,
  parameter int unsigned ACK_TIMEOUT = 7
`endif
) (
  input  logic            clk,
  input  logic            reset,
  usb_in_arbiter_if.slave bus
);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic                 r_port;
  logic                 w_port_nxt;
  logic                 r_last_served;
  logic                 w_last_served_nxt;
  logic [1:0]           r_grant;
  logic [1:0]           w_grant_nxt;
  logic                 r_commit;
  logic                 w_commit_nxt;
  logic [USB_LEN_W-1:0] r_commit_len;
  logic [USB_LEN_W-1:0] w_commit_len_nxt;
  logic [CNT_W-1:0]     r_commits0;
  logic [CNT_W-1:0]     w_commits0_nxt;
  logic [CNT_W-1:0]     r_commits1;
  logic [CNT_W-1:0]     w_commits1_nxt;
  logic [CNT_W-1:0]     r_timeouts;
  logic [CNT_W-1:0]     w_timeouts_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 w_ack_fall;
  logic                 w_timeout;
  logic                 w_release;
  logic                 w_pick;
  logic                 w_done_sel;
  logic                 w_req_sel;
  wr_port_t             w_wr;

  ack_edge_sync u_ack_sync (
    .clk      (clk),
    .reset    (reset),
    .i_ack    (bus.ep3_usb_in_commit_ack),
    .o_fall_c (w_ack_fall)
  );

`ifdef USB_ARB_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1) + 1;

  logic [WAIT_W-1:0] r_wait_cnt;

  // Counts cycles spent waiting for the acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == COMMIT) begin
      r_wait_cnt <= '0;
    end else if ((r_state == WAIT_ACK) && !w_release) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  assign w_timeout = (r_state == WAIT_ACK) && (r_wait_cnt > WAIT_W'(ACK_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_pick     = (&bus.req) ? ~r_last_served : bus.req[1];
  assign w_done_sel = bus.done[r_port];
  assign w_req_sel  = bus.req[r_port];
  assign w_release  = (r_state == WAIT_ACK) && (w_ack_fall || w_timeout);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_port        <= 1'b0;
      r_last_served <= 1'b1;
      r_grant       <= '0;
      r_commit      <= 1'b0;
      r_commit_len  <= '0;
      r_commits0    <= '0;
      r_commits1    <= '0;
      r_timeouts    <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_port        <= w_port_nxt;
      r_last_served <= w_last_served_nxt;
      r_grant       <= w_grant_nxt;
      r_commit      <= w_commit_nxt;
      r_commit_len  <= w_commit_len_nxt;
      r_commits0    <= w_commits0_nxt;
      r_commits1    <= w_commits1_nxt;
      r_timeouts    <= w_timeouts_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  // Next state; a new grant waits until the previous commit has dropped
  always_comb begin
    w_state_nxt = r_state;
    w_port_nxt  = r_port;
    case (r_state)
      IDLE: begin
        if (bus.ep3_usb_in_ready && (|bus.req) && !r_commit) begin
          w_state_nxt = GRANT;
          w_port_nxt  = w_pick;
        end
      end
      GRANT: begin
        if (w_done_sel) begin
          w_state_nxt = COMMIT;
        end else if (!w_req_sel) begin
          w_state_nxt = IDLE;
        end
      end
      COMMIT:   w_state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (w_release) begin
          w_state_nxt = IDLE;
        end
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Output and statistics next values
  always_comb begin
    w_grant_nxt       = '0;
    w_commit_nxt      = 1'b0;
    w_commit_len_nxt  = r_commit_len;
    w_last_served_nxt = r_last_served;
    w_commits0_nxt    = r_commits0;
    w_commits1_nxt    = r_commits1;
    w_timeouts_nxt    = r_timeouts;
    w_busy_nxt        = (w_state_nxt != IDLE);
    if (w_state_nxt == GRANT) begin
      w_grant_nxt = port_onehot(w_port_nxt);
    end
    // Commit follows the state one cycle late, so it falls after IDLE is reached
    if ((r_state == COMMIT) || (r_state == WAIT_ACK)) begin
      w_commit_nxt = 1'b1;
    end
    if ((r_state == GRANT) && w_done_sel) begin
      w_commit_len_nxt = r_port ? bus.len1 : bus.len0;
    end
    if (w_release) begin
      w_last_served_nxt = r_port;
      if (r_port) begin
        w_commits1_nxt = r_commits1 + CNT_W'(1);
      end else begin
        w_commits0_nxt = r_commits0 + CNT_W'(1);
      end
      if (!w_ack_fall) begin
        w_timeouts_nxt = r_timeouts + CNT_W'(1);
      end
    end
  end

  // Zero-latency write mux from the granted requester
  always_comb begin
    w_wr = '0;
    if (r_grant[0]) begin
      w_wr = '{addr: bus.addr0, data: bus.data0, wren: bus.wren0};
    end else if (r_grant[1]) begin
      w_wr = '{addr: bus.addr1, data: bus.data1, wren: bus.wren1};
    end
  end

  assign bus.grant                 = r_grant;
  assign bus.ep3_usb_in_addr       = w_wr.addr;
  assign bus.ep3_usb_in_data       = w_wr.data;
  assign bus.ep3_usb_in_wren       = w_wr.wren;
  assign bus.ep3_usb_in_commit     = r_commit;
  assign bus.ep3_usb_in_commit_len = r_commit_len;
  assign bus.commits0              = r_commits0;
  assign bus.commits1              = r_commits1;
  assign bus.timeouts              = r_timeouts;
  assign bus.busy                  = r_busy;

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Directed/randomised bench for usb_in_arbiter with a transaction-level reference model.
// Honours USB_ARB_TIMEOUT_EN in the same way as the design.
module tb_usb_in_arbiter;
  import usb_arb_pkg::*;

  localparam int unsigned TB_CNT_W       = 3;
  localparam int unsigned TB_ACK_TIMEOUT = 7;
  localparam int unsigned CNT_MASK       = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  usb_in_arbiter_if #(.CNT_W(TB_CNT_W)) bus ();

  usb_in_arbiter #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: who was served last and how many commits/timeouts so far
  int m_last;
  int m_commits[2];
  int m_timeouts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_last       = 1;
    m_commits[0] = 0;
    m_commits[1] = 0;
    m_timeouts   = 0;
  endtask

  task automatic model_release(input int p, input bit timed_out);
    m_commits[p] = (m_commits[p] + 1) & CNT_MASK;
    if (timed_out) m_timeouts = (m_timeouts + 1) & CNT_MASK;
    m_last = p;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_commits0"}, 32'(bus.commits0), 32'(m_commits[0]));
    check({tag, "_commits1"}, 32'(bus.commits1), 32'(m_commits[1]));
    check({tag, "_timeouts"}, 32'(bus.timeouts), 32'(m_timeouts));
  endtask

  task automatic randomise_writes(input bit wren_on, input int p);
    bus.addr0 = 11'($urandom);
    bus.addr1 = 11'($urandom);
    bus.data0 = 8'($urandom);
    bus.data1 = 8'($urandom);
    bus.wren0 = (p == 0) ? wren_on : 1'($urandom);
    bus.wren1 = (p == 1) ? wren_on : 1'($urandom);
  endtask

  // Raise then drop ack; commit must fall three cycles after the falling edge
  task automatic ack_release(input int p);
    int ah;
    ah = int'($urandom_range(1, 4));
    bus.ep3_usb_in_commit_ack = 1'b1;
    repeat (ah) begin
      tick();
      check("ack_high_commit", 32'(bus.ep3_usb_in_commit), 32'd1);
    end
    bus.ep3_usb_in_commit_ack = 1'b0;
    tick();
    check("ack_k1_commit", 32'(bus.ep3_usb_in_commit), 32'd1);
    tick();
    check("ack_k2_commit", 32'(bus.ep3_usb_in_commit), 32'd1);
    check("ack_k2_busy", 32'(bus.busy), 32'd0);
    tick();
    model_release(p, 1'b0);
    check("ack_k3_commit", 32'(bus.ep3_usb_in_commit), 32'd0);
    check("ack_k3_grant", 32'(bus.grant), 32'd0);
    check_counters("ack_k3");
  endtask

  // One transaction; request pattern must already be driven in the current cycle.
  // mode 0: normal ack, 1: ack withheld, 2: reset while waiting for ack
  task automatic serve(input int p, input int nwr, input logic [10:0] len, input int mode);
    tick();
    check("grant_n1", 32'(bus.grant), 32'(onehot(p)));
    check("busy_n1", 32'(bus.busy), 32'd1);
    for (int i = 0; i < nwr; i++) begin
      randomise_writes(1'b1, p);
      #1;
      check("mux_addr", 32'(bus.ep3_usb_in_addr), 32'((p == 1) ? bus.addr1 : bus.addr0));
      check("mux_data", 32'(bus.ep3_usb_in_data), 32'((p == 1) ? bus.data1 : bus.data0));
      check("mux_wren", 32'(bus.ep3_usb_in_wren), 32'd1);
      tick();
    end
    check("grant_hold", 32'(bus.grant), 32'(onehot(p)));
    bus.wren0 = 1'b0;
    bus.wren1 = 1'b0;
    bus.done  = onehot(p) | (2'($urandom) & ~onehot(p));
    if (p == 1) begin
      bus.len1 = len;
      bus.len0 = 11'($urandom);
    end else begin
      bus.len0 = len;
      bus.len1 = 11'($urandom);
    end
    tick();
    bus.done = 2'b00;
    check("m1_grant", 32'(bus.grant), 32'd0);
    check("m1_commit_len", 32'(bus.ep3_usb_in_commit_len), 32'(len));
    check("m1_commit", 32'(bus.ep3_usb_in_commit), 32'd0);
    tick();
    check("m2_commit", 32'(bus.ep3_usb_in_commit), 32'd1);
    if (mode == 0) begin
      ack_release(p);
    end else if (mode == 1) begin
`ifdef USB_ARB_TIMEOUT_EN
      repeat (TB_ACK_TIMEOUT + 1) begin
        tick();
        check("to_commit_high", 32'(bus.ep3_usb_in_commit), 32'd1);
      end
      tick();
      model_release(p, 1'b1);
      check("to_commit_low", 32'(bus.ep3_usb_in_commit), 32'd0);
      check("to_busy", 32'(bus.busy), 32'd0);
      check_counters("to");
`else
      repeat (30) begin
        tick();
        check("noto_commit_high", 32'(bus.ep3_usb_in_commit), 32'd1);
        check("noto_busy", 32'(bus.busy), 32'd1);
      end
      ack_release(p);
`endif
    end else begin
      tick();
      reset    = 1'b1;
      bus.req  = 2'b00;
      tick();
      reset    = 1'b0;
      model_reset();
      check("rst_commit", 32'(bus.ep3_usb_in_commit), 32'd0);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_commit_len", 32'(bus.ep3_usb_in_commit_len), 32'd0);
      check_counters("rst");
    end
  endtask

  task automatic reset_dut();
    reset                     = 1'b1;
    bus.req                   = 2'b00;
    bus.done                  = 2'b00;
    bus.len0                  = '0;
    bus.len1                  = '0;
    bus.ep3_usb_in_ready      = 1'b1;
    bus.ep3_usb_in_commit_ack = 1'b0;
    randomise_writes(1'b0, 0);
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int p;
    logic [1:0] rq;

    // reset state
    reset_dut();
    bus.wren0 = 1'b1;
    bus.wren1 = 1'b1;
    #1;
    check("reset_grant", 32'(bus.grant), 32'd0);
    check("reset_commit", 32'(bus.ep3_usb_in_commit), 32'd0);
    check("reset_commit_len", 32'(bus.ep3_usb_in_commit_len), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_mux_addr", 32'(bus.ep3_usb_in_addr), 32'd0);
    check("reset_mux_data", 32'(bus.ep3_usb_in_data), 32'd0);
    check("reset_mux_wren", 32'(bus.ep3_usb_in_wren), 32'd0);
    check_counters("reset");

    // single request, four writes, length 4
    bus.req = 2'b01;
    serve(0, 4, 11'd4, 0);
    bus.req = 2'b00;

    // contention from a fresh reset: round robin starting at port 0
    reset_dut();
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      p = (m_last == 0) ? 1 : 0;
      serve(p, int'($urandom_range(1, 5)), 11'($urandom), 0);
    end
    bus.req = 2'b00;
    check_counters("contention");

    // endpoint not ready holds off the grant
    bus.ep3_usb_in_ready = 1'b0;
    bus.req              = 2'b10;
    repeat (20) begin
      tick();
      randomise_writes(1'b1, 1);
      #1;
      check("notready_grant", 32'(bus.grant), 32'd0);
      check("notready_wren", 32'(bus.ep3_usb_in_wren), 32'd0);
      check("notready_addr", 32'(bus.ep3_usb_in_addr), 32'd0);
    end
    bus.ep3_usb_in_ready = 1'b1;
    serve(1, 3, 11'($urandom), 0);
    bus.req = 2'b00;

    // abort: request withdrawn during grant
    bus.req = 2'b01;
    tick();
    check("abort_grant", 32'(bus.grant), 32'd1);
    bus.req = 2'b00;
    tick();
    check("abort_grant_low", 32'(bus.grant), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    repeat (3) begin
      tick();
      check("abort_commit", 32'(bus.ep3_usb_in_commit), 32'd0);
    end
    check_counters("abort");
    bus.req = 2'b11;
    serve((m_last == 0) ? 1 : 0, 2, 11'($urandom), 0);
    bus.req = 2'b00;

    // zero-length commit
    bus.req = 2'b01;
    serve(0, 2, 11'd0, 0);
    bus.req = 2'b00;

    // randomised request patterns, including done in the grant cycle
    repeat (12) begin
      rq = 2'($urandom_range(1, 3));
      if (rq == 2'b11) p = (m_last == 0) ? 1 : 0;
      else             p = (rq == 2'b10) ? 1 : 0;
      bus.req = rq;
      serve(p, int'($urandom_range(0, 4)), 11'($urandom), 0);
    end
    bus.req = 2'b00;

    // ack withheld
    bus.req = 2'b10;
    serve(1, 2, 11'($urandom), 1);
    bus.req = 2'b00;

    // reset while waiting for ack
    bus.req = 2'b01;
    serve(0, 1, 11'($urandom), 2);
    bus.req = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
